// File: rtl/decoder_pkg.sv
// Shared types and helpers for the scanning one-hot decoder.
// Latency: none (package only).
// Backpressure: none (package only).
`timescale 1ns/1ps
package decoder_pkg;

    // Widest select the decoder supports; onehot() is sized for it.
    localparam int MAX_SEL_W = 6;

    // Controller state encoding, kept as plain constants for legacy tools.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE       = 2'd0;
    localparam state_t ST_DECODE     = 2'd1;
    localparam state_t ST_SCAN_HOLD  = 2'd2;
    localparam state_t ST_SCAN_BLANK = 2'd3;

    // Scan direction encoding as seen on the dir input.
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // One-hot of an index at the widest supported size; callers truncate.
    function automatic logic [(1 << MAX_SEL_W)-1:0] onehot(input logic [MAX_SEL_W-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

endpackage

// File: rtl/decoder_scan_nto2n_dwell_timer.sv
// Loadable dwell down-counter; expire is high while one cycle of dwell remains.
// Latency: load takes effect on the next edge; expire is combinational from the count.
// Backpressure: none; tick is simply ignored once the count reaches zero.
`timescale 1ns/1ps
module dwell_timer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               tick,
    input  logic [DWELL_W-1:0] dwell,
    output logic               expire
);

    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] load_val;

    // A zero dwell behaves as a one-cycle hold.
    assign load_val = (dwell == '0) ? DWELL_W'(1) : dwell;

    // Reload has priority over counting down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (tick && (cnt != '0)) begin
            cnt <= cnt - DWELL_W'(1);
        end
    end

    assign expire = (cnt == DWELL_W'(1));

endmodule

// File: rtl/decoder_scan_nto2n.sv
// Registered N-to-2^N one-hot decoder with auto-scan sequencer (optional DECODER_SCAN_BLANK_EN gap cycle).
// Latency: 1 cycle from sel/en/mode/load to d_out, idx and wrap.
// Backpressure: none; en=0 blanks outputs on the next edge, load beats dwell expiry.
`timescale 1ns/1ps
module decoder_scan_nto2n
    import decoder_pkg::*;
#(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    load,
    input  logic                    dir,
    input  logic [DWELL_W-1:0]      dwell,
    output logic [(1 << SEL_W)-1:0] d_out,
    output logic [SEL_W-1:0]        idx,
    output logic                    wrap
);

    localparam int NOUT = 1 << SEL_W;

    state_t           state_q;
    state_t           state_d;
    logic [SEL_W-1:0] idx_d;
    logic [SEL_W-1:0] idx_step;
    logic             wrap_d;
    logic             wrap_step;
    logic             drive_d;
    logic [NOUT-1:0]  d_out_d;
    logic             dir_q;
    logic             tmr_load;
    logic             tmr_tick;
    logic             tmr_expire;

    dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (tmr_load),
        .tick   (tmr_tick),
        .dwell  (dwell),
        .expire (tmr_expire)
    );

    // Next scan index uses the direction latched at the last reload; the
    // natural SEL_W-bit overflow gives the modulo-2^N wrap.
    always_comb begin
        idx_step  = (dir_q == DIR_DOWN) ? idx - SEL_W'(1) : idx + SEL_W'(1);
        wrap_step = (dir_q == DIR_UP) ? (&idx) : (idx == '0);
    end

    // Controller: en gates everything, then mode, then load, then dwell expiry.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx;
        wrap_d   = 1'b0;
        drive_d  = 1'b0;
        tmr_load = 1'b0;
        tmr_tick = 1'b0;
        if (!en) begin
            state_d = ST_IDLE;
        end else if (!mode) begin
            state_d = ST_DECODE;
            idx_d   = sel;
            drive_d = 1'b1;
        end else if (load || (state_q == ST_IDLE) || (state_q == ST_DECODE)) begin
            // Scan entry and explicit load both restart at sel with a fresh dwell.
            state_d  = ST_SCAN_HOLD;
            idx_d    = sel;
            drive_d  = 1'b1;
            tmr_load = 1'b1;
        end else begin
            case (state_q)
                ST_SCAN_HOLD: begin
                    drive_d = 1'b1;
                    if (tmr_expire) begin
`ifdef DECODER_SCAN_BLANK_EN
                        // Break before make: one dark cycle before the next index.
                        state_d = ST_SCAN_BLANK;
                        drive_d = 1'b0;
`else
                        idx_d    = idx_step;
                        wrap_d   = wrap_step;
                        tmr_load = 1'b1;
`endif
                    end else begin
                        tmr_tick = 1'b1;
                    end
                end
                ST_SCAN_BLANK: begin
`ifdef DECODER_SCAN_BLANK_EN
                    state_d  = ST_SCAN_HOLD;
                    idx_d    = idx_step;
                    wrap_d   = wrap_step;
                    drive_d  = 1'b1;
                    tmr_load = 1'b1;
`else
                    // Not reachable in this build; fall back to a safe state.
                    state_d = ST_IDLE;
`endif
                end
                default: state_d = ST_IDLE;
            endcase
        end
        d_out_d = drive_d ? NOUT'(onehot(MAX_SEL_W'(idx_d))) : '0;
    end

    // Register outputs so d_out is glitch-free and exactly one-hot or zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx     <= '0;
            wrap    <= 1'b0;
            d_out   <= '0;
            dir_q   <= DIR_UP;
        end else begin
            state_q <= state_d;
            idx     <= idx_d;
            wrap    <= wrap_d;
            d_out   <= d_out_d;
            if (tmr_load) begin
                dir_q <= dir;
            end
        end
    end

endmodule

// File: tb/tb_decoder_scan_nto2n.sv
`timescale 1ns/1ps
module tb_decoder_scan_nto2n;

    localparam int SEL_W   = 3;
    localparam int DWELL_W = 8;
    localparam int NOUT    = 1 << SEL_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             mode;
    logic [SEL_W-1:0] sel;
    logic             load;
    logic             dir;
    logic [DWELL_W-1:0] dwell;
    logic [NOUT-1:0]  d_out;
    logic [SEL_W-1:0] idx;
    logic             wrap;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    decoder_scan_nto2n #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .mode  (mode),
        .sel   (sel),
        .load  (load),
        .dir   (dir),
        .dwell (dwell),
        .d_out (d_out),
        .idx   (idx),
        .wrap  (wrap)
    );

    // Reference model: what is lit, for how many more cycles, which way next.
    int              m_kind;   // 0 off, 1 direct decode, 2 scanning
    int              m_idx;
    int              m_left;   // cycles of the current hold still to show
    int              m_dir;
    int              m_blank;
    logic [NOUT-1:0] m_out;
    logic            m_wrap;

    task automatic model_reset();
        m_kind = 0; m_idx = 0; m_left = 0; m_dir = 0; m_blank = 0;
        m_out = '0; m_wrap = 1'b0;
    endtask

    task automatic model_start(input int s);
        m_kind  = 2;
        m_idx   = s;
        m_left  = (dwell == 0) ? 1 : int'(dwell);
        m_dir   = int'(dir);
        m_out   = NOUT'(1 << s);
        m_blank = 0;
    endtask

    task automatic model_advance();
        int nxt;
        nxt     = (m_dir != 0) ? (m_idx + NOUT - 1) % NOUT : (m_idx + 1) % NOUT;
        m_wrap  = (m_dir != 0) ? (nxt > m_idx) : (nxt < m_idx);
        m_idx   = nxt;
        m_left  = (dwell == 0) ? 1 : int'(dwell);
        m_dir   = int'(dir);
        m_out   = NOUT'(1 << nxt);
        m_blank = 0;
    endtask

    // Apply one clock edge of the specified behaviour to the model.
    task automatic model_edge();
        m_wrap = 1'b0;
        if (!en) begin
            m_kind = 0; m_out = '0; m_blank = 0;
        end else if (!mode) begin
            m_kind = 1; m_idx = int'(sel); m_out = NOUT'(1 << sel); m_blank = 0;
        end else if (m_kind != 2 || load) begin
            model_start(int'(sel));
        end else if (m_blank != 0) begin
            model_advance();
        end else if (m_left == 1) begin
`ifdef DECODER_SCAN_BLANK_EN
            m_blank = 1; m_out = '0;
`else
            model_advance();
`endif
        end else begin
            m_left--;
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // idx is only meaningful while an output is lit.
    task automatic check_out(input string tag, input logic [NOUT-1:0] e_out, input int e_idx,
                             input logic e_wrap);
        check({tag, ".d_out"}, 64'(d_out), 64'(e_out));
        check({tag, ".wrap"}, 64'(wrap), 64'(e_wrap));
        if (e_out != '0) check({tag, ".idx"}, 64'(idx), 64'(e_idx));
    endtask

    // Drive inputs at the falling edge, step the model at the rising edge,
    // leave time 1ns after the rising edge for sampling.
    task automatic drive_step(input logic e, input logic m, input int s, input logic l,
                              input logic d, input int dw);
        @(negedge clk);
        en = e; mode = m; sel = SEL_W'(s); load = l; dir = d; dwell = DWELL_W'(dw);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    typedef struct {
        logic            en;
        logic            mode;
        int              sel;
        logic            load;
        logic            dir;
        int              dwell;
        logic [NOUT-1:0] e_out;
        int              e_idx;
        logic            e_wrap;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic e, input logic m, input int s, input logic l, input logic d,
                       input int dw, input int eo, input int ei, input logic ew);
        vec_t v;
        v.en = e; v.mode = m; v.sel = s; v.load = l; v.dir = d; v.dwell = dw;
        v.e_out = NOUT'(eo); v.e_idx = ei; v.e_wrap = ew;
        vecs.push_back(v);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic e_r, m_r, l_r, d_r;
        int   s_r, dw_r;

        rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel = '0; load = 1'b0; dir = 1'b0; dwell = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_out("reset", '0, 0, 1'b0);
        check("reset.idx", 64'(idx), 64'd0);
        rst_n = 1'b1;

`ifndef DECODER_SCAN_BLANK_EN
        //   en mode sel load dir dwell | d_out idx wrap
        add(1, 0, 5, 0, 0, 3,  'h20, 5, 0);  // decode sel=5
        add(1, 0, 2, 0, 0, 3,  'h04, 2, 0);
        add(0, 0, 2, 0, 0, 3,  'h00, 0, 0);  // en drop blanks next edge
        add(1, 0, 2, 0, 0, 3,  'h04, 2, 0);
        add(1, 1, 6, 0, 0, 3,  'h40, 6, 0);  // scan up from 6, dwell 3
        add(1, 1, 6, 0, 0, 3,  'h40, 6, 0);
        add(1, 1, 6, 0, 0, 3,  'h40, 6, 0);
        add(1, 1, 6, 0, 0, 3,  'h80, 7, 0);
        add(1, 1, 6, 0, 0, 3,  'h80, 7, 0);
        add(1, 1, 6, 0, 0, 3,  'h80, 7, 0);
        add(1, 1, 6, 0, 0, 3,  'h01, 0, 1);  // wrap up
        add(1, 1, 6, 0, 0, 3,  'h01, 0, 0);
        add(1, 1, 1, 1, 1, 0,  'h02, 1, 0);  // load 1, down, dwell 0
        add(1, 1, 1, 0, 1, 0,  'h01, 0, 0);
        add(1, 1, 1, 0, 1, 0,  'h80, 7, 1);  // wrap down
        add(1, 1, 1, 0, 1, 0,  'h40, 6, 0);
        add(1, 1, 1, 0, 0, 2,  'h20, 5, 0);  // step uses dir latched at reload
        add(1, 1, 1, 0, 0, 2,  'h20, 5, 0);
        add(1, 1, 4, 1, 0, 2,  'h10, 4, 0);  // load coincides with expiry
        add(1, 1, 4, 0, 0, 2,  'h10, 4, 0);  // full dwell restarted
        add(1, 1, 4, 0, 0, 2,  'h20, 5, 0);
        add(1, 0, 3, 0, 0, 2,  'h08, 3, 0);  // back to decode
        add(0, 0, 3, 0, 0, 2,  'h00, 0, 0);
        add(1, 0, 7, 0, 0, 2,  'h80, 7, 0);  // top index
        add(1, 0, 0, 0, 0, 2,  'h01, 0, 0);  // bottom index
        add(1, 1, 7, 0, 0, 1,  'h80, 7, 0);
        add(1, 1, 7, 0, 0, 1,  'h01, 0, 1);
        add(0, 1, 7, 0, 0, 1,  'h00, 0, 0);
        for (int i = 0; i < vecs.size(); i++) begin
            drive_step(vecs[i].en, vecs[i].mode, vecs[i].sel, vecs[i].load, vecs[i].dir,
                       vecs[i].dwell);
            check_out($sformatf("vec%0d", i), vecs[i].e_out, vecs[i].e_idx, vecs[i].e_wrap);
        end
`else
        // Break-before-make scan: one dark cycle between held indices.
        drive_step(1, 1, 2, 0, 0, 2);  check_out("blank.enter", 'h04, 2, 1'b0);
        drive_step(1, 1, 2, 0, 0, 2);  check_out("blank.hold", 'h04, 2, 1'b0);
        drive_step(1, 1, 2, 0, 0, 2);  check_out("blank.gap1", 'h00, 0, 1'b0);
        drive_step(1, 1, 2, 0, 0, 2);  check_out("blank.next", 'h08, 3, 1'b0);
        drive_step(1, 1, 2, 0, 0, 2);  check_out("blank.hold2", 'h08, 3, 1'b0);
        drive_step(1, 1, 2, 0, 0, 2);  check_out("blank.gap2", 'h00, 0, 1'b0);
        drive_step(1, 1, 6, 1, 0, 2);  check_out("blank.load", 'h40, 6, 1'b0);
        drive_step(1, 1, 7, 1, 0, 1);  check_out("blank.load7", 'h80, 7, 1'b0);
        drive_step(1, 1, 7, 0, 0, 1);  check_out("blank.gap3", 'h00, 0, 1'b0);
        drive_step(1, 1, 7, 0, 0, 1);  check_out("blank.wrap", 'h01, 0, 1'b1);
        drive_step(0, 1, 7, 0, 0, 1);  check_out("blank.off", 'h00, 0, 1'b0);
`endif

        // Asynchronous reset mid-hold, between clock edges.
        drive_step(1, 1, 3, 0, 0, 5);  check_out("arst.enter", 'h08, 3, 1'b0);
        drive_step(1, 1, 3, 0, 0, 5);  check_out("arst.hold", 'h08, 3, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("arst.immediate", '0, 0, 1'b0);
        check("arst.idx", 64'(idx), 64'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive_step(1, 1, 3, 0, 0, 5);  check_out("arst.resume", 'h08, 3, 1'b0);

        // Randomised run against the model; dwell/dir change freely mid-hold.
        m_r = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            e_r  = ($urandom_range(0, 24) != 0);
            if ($urandom_range(0, 19) == 0) m_r = ~m_r;
            s_r  = int'($urandom_range(0, NOUT - 1));
            l_r  = ($urandom_range(0, 11) == 0);
            d_r  = $urandom_range(0, 1) != 0;
            dw_r = int'($urandom_range(0, 4));
            drive_step(e_r, m_r, s_r, l_r, d_r, dw_r);
            check_out($sformatf("rand%0d", c), m_out, m_idx, m_wrap);
            check($sformatf("rand%0d.onehot0", c), 64'($countones(d_out) <= 1), 64'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
